// File: rtl/mux4_rr_scan.sv
// Round-robin scanner for an external 4:1 mux: grants a requesting channel,
// drives SEL, waits SETTLE_CYC cycles, then captures MUX_OUT with a valid/ready handshake.
module mux4_rr_scan #(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] REQ,
   input  logic       MUX_OUT,
   output logic [1:0] SEL,
   output logic       DOUT,
   output logic [1:0] DOUT_CH,
   output logic       DOUT_VALID,
   input  logic       DOUT_READY,
   output logic       BUSY
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

   state_t     state;
   logic [1:0] last;
   logic [3:0] cnt;
   logic [1:0] grant;
   logic [1:0] idx;
   logic       found;

   // First set REQ bit searching upward from last+1; 2-bit arithmetic wraps 3->0.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (REQ[idx] && !found) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         SEL        <= '0;
         DOUT       <= 1'b0;
         DOUT_CH    <= '0;
         DOUT_VALID <= 1'b0;
         BUSY       <= 1'b0;
         last       <= '1;
         cnt        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (REQ != '0) begin
                  SEL   <= grant;
                  cnt   <= CNT_INIT;
                  state <= SETTLE;
                  BUSY  <= 1'b1;
               end
            end
            SETTLE: begin
               // A dropped request aborts even on the final settle cycle.
               if (!REQ[SEL]) begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
                  cnt   <= '0;
               end else if (cnt == '0) begin
                  DOUT       <= MUX_OUT;
                  DOUT_CH    <= SEL;
                  DOUT_VALID <= 1'b1;
                  state      <= HOLD;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            HOLD: begin
               if (DOUT_READY) begin
                  DOUT_VALID <= 1'b0;
                  last       <= SEL;
                  state      <= IDLE;
                  BUSY       <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               BUSY  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_scan.sv
// Directed plus randomized bench for mux4_rr_scan against a transaction-level
// round-robin model; a second instance with SETTLE_CYC=4 covers the abort case.
module tb_mux4_rr_scan;

   localparam int unsigned SC  = 2;
   localparam int unsigned SC4 = 4;

   logic       CLK;
   logic       RST_N;
   logic [3:0] REQ;
   logic       MUX_OUT;
   logic [1:0] SEL;
   logic       DOUT;
   logic [1:0] DOUT_CH;
   logic       DOUT_VALID;
   logic       DOUT_READY;
   logic       BUSY;

   logic [3:0] req4;
   logic       mux4;
   logic [1:0] sel4;
   logic       dout4;
   logic [1:0] dout_ch4;
   logic       valid4;
   logic       ready4;
   logic       busy4;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int          m_last;

   mux4_rr_scan #(.SETTLE_CYC(SC)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .MUX_OUT(MUX_OUT), .SEL(SEL),
      .DOUT(DOUT), .DOUT_CH(DOUT_CH), .DOUT_VALID(DOUT_VALID),
      .DOUT_READY(DOUT_READY), .BUSY(BUSY)
   );

   mux4_rr_scan #(.SETTLE_CYC(SC4)) u_dut4 (
      .CLK(CLK), .RST_N(RST_N), .REQ(req4), .MUX_OUT(mux4), .SEL(sel4),
      .DOUT(dout4), .DOUT_CH(dout_ch4), .DOUT_VALID(valid4),
      .DOUT_READY(ready4), .BUSY(busy4)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Round-robin rule: first requesting channel after the last served one, modulo 4.
   function automatic logic [1:0] rr_pick(input int last, input logic [3:0] r);
      for (int k = 1; k <= 4; k++)
         if (r[(last + k) % 4]) return 2'((last + k) % 4);
      return 2'd0;
   endfunction

   task automatic txn(input logic [3:0] r, input logic m, input int unsigned dly);
      logic [1:0]  exp_ch;
      int unsigned n;
      exp_ch     = rr_pick(m_last, r);
      REQ        = r;
      MUX_OUT    = m;
      DOUT_READY = (dly == 0);
      step();
      check("grant_sel", 32'(SEL), 32'(exp_ch));
      check("grant_busy", 32'(BUSY), 32'd1);
      n = 1;
      while (!DOUT_VALID && n < 40) begin
         step();
         n++;
         if (!DOUT_VALID) check("settle_sel", 32'(SEL), 32'(exp_ch));
      end
      check("latency", 32'(n), 32'(SC + 1));
      check("dout", 32'(DOUT), 32'(m));
      check("dout_ch", 32'(DOUT_CH), 32'(exp_ch));
      for (int unsigned i = 0; i < dly; i++) begin
         DOUT_READY = 1'b0;
         REQ        = 4'($urandom);
         MUX_OUT    = ~MUX_OUT;
         step();
         check("hold_valid", 32'(DOUT_VALID), 32'd1);
         check("hold_dout", 32'(DOUT), 32'(m));
         check("hold_ch", 32'(DOUT_CH), 32'(exp_ch));
         check("hold_sel", 32'(SEL), 32'(exp_ch));
      end
      DOUT_READY = 1'b1;
      step();
      check("hs_valid", 32'(DOUT_VALID), 32'd0);
      check("hs_busy", 32'(BUSY), 32'd0);
      check("hs_sel", 32'(SEL), 32'(exp_ch));
      REQ        = 4'd0;
      DOUT_READY = 1'b0;
      m_last     = int'(exp_ch);
   endtask

   initial begin
      int unsigned samples;
      int unsigned e;
      int unsigned prev;
      logic [1:0]  exp_ch;

      RST_N = 1'b0; REQ = 4'd0; MUX_OUT = 1'b0; DOUT_READY = 1'b0;
      req4 = 4'd0; mux4 = 1'b0; ready4 = 1'b1;
      #2;
      check("rst_sel", 32'(SEL), 32'd0);
      check("rst_valid", 32'(DOUT_VALID), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_dout", 32'(DOUT), 32'd0);
      check("rst_ch", 32'(DOUT_CH), 32'd0);
      step();
      step();
      RST_N  = 1'b1;
      m_last = 3;

      // Reach HOLD on channel 2 with backpressure, then reset between edges.
      REQ = 4'b0100; MUX_OUT = 1'b1;
      step();
      check("r28_sel", 32'(SEL), 32'd2);
      step();
      step();
      check("r28_valid", 32'(DOUT_VALID), 32'd1);
      check("r28_ch", 32'(DOUT_CH), 32'd2);
      step();
      check("r28_hold", 32'(DOUT_VALID), 32'd1);
      #2 RST_N = 1'b0;
      #1;
      check("r28_async_valid", 32'(DOUT_VALID), 32'd0);
      check("r28_async_sel", 32'(SEL), 32'd0);
      check("r28_async_busy", 32'(BUSY), 32'd0);
      #1 RST_N = 1'b1;
      m_last = 3;

      // Fairness with all requests held and ready high.
      REQ = 4'b1111; DOUT_READY = 1'b1;
      step();
      check("r28_first_grant", 32'(SEL), 32'd0);
      samples = 0; e = 1; prev = 0;
      while (samples < 5 && e < 60) begin
         step();
         e++;
         if (DOUT_VALID) begin
            exp_ch = rr_pick(m_last, 4'b1111);
            m_last = int'(exp_ch);
            check("fair_ch", 32'(DOUT_CH), 32'(exp_ch));
            if (samples > 0) check("fair_space", 32'(e - prev), 32'(SC + 2));
            prev = e;
            samples++;
            if (samples == 5) REQ = 4'd0;
         end
      end
      check("fair_count", 32'(samples), 32'd5);
      step();
      check("fair_idle_busy", 32'(BUSY), 32'd0);
      DOUT_READY = 1'b0;

      txn(4'b0100, 1'b1, 0);
      check("wrap_start", 32'(m_last), 32'd2);
      txn(4'b1001, 1'b0, 0);
      check("wrap_to3", 32'(m_last), 32'd3);
      txn(4'b1001, 1'b1, 0);
      check("wrap_to0", 32'(m_last), 32'd0);
      txn(4'b1001, 1'b0, 1);
      check("wrap_back3", 32'(m_last), 32'd3);
      txn(4'b0001, 1'b1, 10);

      for (int t = 0; t < 25; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            REQ = 4'd0;
            DOUT_READY = 1'($urandom);
            for (int k = 0; k < 3; k++) begin
               step();
               check("idle_busy", 32'(BUSY), 32'd0);
               check("idle_sel", 32'(SEL), 32'(m_last));
               check("idle_valid", 32'(DOUT_VALID), 32'd0);
            end
         end
         txn(4'($urandom_range(1, 15)), 1'($urandom), $urandom_range(0, 3));
      end

      // Abort on the SETTLE_CYC=4 instance: request dropped in 2nd settle cycle.
      req4 = 4'b1000;
      step();
      check("ab_sel", 32'(sel4), 32'd3);
      step();
      req4 = 4'b0000;
      step();
      check("ab_busy", 32'(busy4), 32'd0);
      check("ab_sel_kept", 32'(sel4), 32'd3);
      for (int k = 0; k < 4; k++) begin
         step();
         check("ab_novalid", 32'(valid4), 32'd0);
      end
      req4 = 4'b1001; mux4 = 1'b1;
      step();
      check("ab_next_grant", 32'(sel4), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("ab_wait", 32'(valid4), 32'd0);
      end
      step();
      check("ab_valid", 32'(valid4), 32'd1);
      check("ab_dout", 32'(dout4), 32'd1);
      check("ab_ch", 32'(dout_ch4), 32'd0);
      req4 = 4'd0;
      step();
      check("ab_hs", 32'(valid4), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
